// File: rtl/varredura_display.sv
// Scan controller for N BCD digits sharing one 7-segment decoder, with a double-buffered load.
// Optional macro SUPRIME_ZERO_EN enables leading-zero blanking.
module varredura_display #(
    parameter int N_DIGITOS = 4,
    parameter int DIV_SLOT  = 50000,
    parameter int GUARDA    = 2,
    parameter int LARG_CNT  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   carga,
    input  logic [4*N_DIGITOS-1:0] dado,
    output logic                   pronto,
    output logic [3:0]             bcd_dec,
    output logic [N_DIGITOS-1:0]   anodo,
    output logic                   fim_quadro
);

    localparam int LARG_IDX = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam logic [LARG_CNT-1:0] CNT_MAX    = LARG_CNT'(DIV_SLOT - 1);
    localparam logic [LARG_CNT-1:0] CNT_GUARDA = LARG_CNT'(GUARDA);
    localparam logic [LARG_IDX-1:0] IDX_MAX    = LARG_IDX'(N_DIGITOS - 1);

    typedef enum logic {APAGADO, ACESO} estado_t;

    logic [LARG_CNT-1:0]    r_cnt;
    logic [LARG_IDX-1:0]    r_idx;
    estado_t                r_estado;
    logic [4*N_DIGITOS-1:0] r_pend;
    logic [4*N_DIGITOS-1:0] r_ativo;

    logic [LARG_CNT-1:0]    w_cntNext;
    logic [LARG_IDX-1:0]    w_idxNext;
    logic                   w_fimQuadro;
    logic                   w_aceita;
    logic                   w_transfere;
    logic                   w_prontoNext;
    logic [4*N_DIGITOS-1:0] w_ativoNext;
    estado_t                w_estadoNext;
    logic [N_DIGITOS-1:0]   w_anodoNext;
    logic [3:0]             w_bcdNext;
    logic                   w_fimNext;

    // pronto doubles as the inverted pending flag; the pending word moves to the active buffer only at frame end
    always_comb begin
        w_cntNext    = (r_cnt == CNT_MAX) ? '0 : r_cnt + LARG_CNT'(1);
        w_idxNext    = r_idx;
        if (r_cnt == CNT_MAX)
            w_idxNext = (r_idx == IDX_MAX) ? '0 : r_idx + LARG_IDX'(1);
        w_fimQuadro  = (r_cnt == CNT_MAX) && (r_idx == IDX_MAX);
        w_aceita     = carga && pronto;
        w_transfere  = w_fimQuadro && !pronto;
        w_ativoNext  = w_transfere ? r_pend : r_ativo;
        w_prontoNext = pronto;
        if (w_aceita)
            w_prontoNext = 1'b0;
        else if (w_transfere)
            w_prontoNext = 1'b1;
    end

    // Outputs are computed from next-cycle state so the registered pins line up with cnt/idx
    always_comb begin
        w_estadoNext = r_estado;
        w_anodoNext  = '1;
        w_bcdNext    = w_ativoNext[{w_idxNext, 2'b00} +: 4];
        w_fimNext    = (w_cntNext == CNT_MAX) && (w_idxNext == IDX_MAX);
        case (r_estado)
            APAGADO: if (w_cntNext >= CNT_GUARDA) w_estadoNext = ACESO;
            ACESO:   if (r_cnt == CNT_MAX)        w_estadoNext = APAGADO;
            default: w_estadoNext = APAGADO;
        endcase
`ifdef SUPRIME_ZERO_EN
        if ((w_idxNext != '0) && ((w_ativoNext >> {w_idxNext, 2'b00}) == '0))
            w_bcdNext = 4'hF;
`else
`endif
        if (w_estadoNext == ACESO)
            w_anodoNext[w_idxNext] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_estado   <= APAGADO;
            r_pend     <= '0;
            r_ativo    <= '1;
            pronto     <= 1'b1;
            bcd_dec    <= 4'hF;
            anodo      <= '1;
            fim_quadro <= 1'b0;
        end else begin
            r_cnt      <= w_cntNext;
            r_idx      <= w_idxNext;
            r_estado   <= w_estadoNext;
            if (w_aceita)
                r_pend <= dado;
            r_ativo    <= w_ativoNext;
            pronto     <= w_prontoNext;
            bcd_dec    <= w_bcdNext;
            anodo      <= w_anodoNext;
            fim_quadro <= w_fimNext;
        end
    end

endmodule
